// File: rtl/hazard_flush_controller.sv
// Stall / freeze / flush sequencer for the five-stage MIPS pipeline.
// Optional perf counters are enabled by defining HAZARD_PERF_COUNTERS_EN.
module hazard_flush_controller #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs_i,
    input  logic [4:0]           id_rt_i,
    input  logic                 id_uses_rt_i,
    input  logic                 ex_mem_read_i,
    input  logic [4:0]           ex_write_register_i,
    input  logic                 redirect_i,
    input  logic                 mem_busy_i,
    output logic                 pc_enable_o,
    output logic                 ifid_enable_o,
    output logic                 ifid_flush_o,
    output logic                 idex_enable_o,
    output logic                 idex_flush_o,
    output logic                 pipe_enable_o,
    output logic                 stall_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o,
    output logic [CNT_WIDTH-1:0] flush_events_o,
    output logic [CNT_WIDTH-1:0] freeze_cycles_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } state_t;

    localparam logic [2:0] BUBBLES_M1 = 3'(LOAD_USE_BUBBLES - 1);

    state_t     state_reg, state_next;
    state_t     ret_state_reg, ret_state_next;
    state_t     eff_state;
    logic [2:0] bubble_cnt_reg, bubble_cnt_next;
    logic       load_use;
    logic       lu_active;

    assign load_use = ex_mem_read_i && (ex_write_register_i != 5'd0) &&
                      ((ex_write_register_i == id_rs_i) ||
                       (id_uses_rt_i && (ex_write_register_i == id_rt_i)));

    // Leaving FREEZE behaves exactly like the state that was interrupted.
    assign eff_state = (state_reg == FREEZE) ? ret_state_reg : state_reg;
    assign lu_active = (eff_state == LU_STALL) || ((eff_state == RUN) && load_use);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= RUN;
            ret_state_reg  <= RUN;
            bubble_cnt_reg <= 3'd0;
        end else begin
            state_reg      <= state_next;
            ret_state_reg  <= ret_state_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    always_comb begin
        state_next      = RUN;
        ret_state_next  = ret_state_reg;
        bubble_cnt_next = bubble_cnt_reg;
        if (mem_busy_i) begin
            state_next = FREEZE;
            if (state_reg != FREEZE) begin
                ret_state_next = state_reg;
            end
        end else if (redirect_i) begin
            state_next      = RUN;
            ret_state_next  = RUN;
            bubble_cnt_next = 3'd0;
        end else if (eff_state == LU_STALL) begin
            bubble_cnt_next = bubble_cnt_reg - 3'd1;
            state_next      = (bubble_cnt_reg == 3'd1) ? RUN : LU_STALL;
        end else if (load_use && (LOAD_USE_BUBBLES > 1)) begin
            state_next      = LU_STALL;
            bubble_cnt_next = BUBBLES_M1;
        end
    end

    always_comb begin
        pc_enable_o   = 1'b1;
        ifid_enable_o = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_enable_o = 1'b1;
        idex_flush_o  = 1'b0;
        pipe_enable_o = 1'b1;
        stall_o       = 1'b0;
        if (!reset) begin
            if (mem_busy_i) begin
                pc_enable_o   = 1'b0;
                ifid_enable_o = 1'b0;
                idex_enable_o = 1'b0;
                pipe_enable_o = 1'b0;
                stall_o       = 1'b1;
            end else if (redirect_i) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (lu_active) begin
                // Hold PC and IF/ID; ID/EX loads a bubble via its flush.
                pc_enable_o   = 1'b0;
                ifid_enable_o = 1'b0;
                idex_flush_o  = 1'b1;
                stall_o       = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] stall_cycles_reg, flush_events_reg, freeze_cycles_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_reg  <= '0;
            flush_events_reg  <= '0;
            freeze_cycles_reg <= '0;
        end else begin
            if (stall_o && !mem_busy_i && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_WIDTH'(1);
            end
            if (redirect_i && !mem_busy_i && (flush_events_reg != '1)) begin
                flush_events_reg <= flush_events_reg + CNT_WIDTH'(1);
            end
            if (mem_busy_i && (freeze_cycles_reg != '1)) begin
                freeze_cycles_reg <= freeze_cycles_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles_o  = stall_cycles_reg;
    assign flush_events_o  = flush_events_reg;
    assign freeze_cycles_o = freeze_cycles_reg;
`else
    assign stall_cycles_o  = '0;
    assign flush_events_o  = '0;
    assign freeze_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Bench for hazard_flush_controller: two instances (1 and 3 bubbles) on shared
// stimulus, a per-cycle behavioural model, and pinned literal expectations.
module tb_hazard_flush_controller;

`ifdef HAZARD_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, pipe_en, stall}
    localparam logic [6:0] O_DEF = 7'b1101010;
    localparam logic [6:0] O_FRZ = 7'b0000001;
    localparam logic [6:0] O_RDR = 7'b1111110;
    localparam logic [6:0] O_STL = 7'b0001111;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_wr;
    logic       uses_rt, mem_read, redirect, mem_busy;

    logic pc1, ifen1, iffl1, iden1, idfl1, pipe1, st1;
    logic pc3, ifen3, iffl3, iden3, idfl3, pipe3, st3;
    logic [31:0] sc1, fe1, fc1, sc3, fe3, fc3;

    always #5 clk = ~clk;

    hazard_flush_controller #(.LOAD_USE_BUBBLES(1), .CNT_WIDTH(32)) u1 (
        .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(uses_rt), .ex_mem_read_i(mem_read), .ex_write_register_i(ex_wr),
        .redirect_i(redirect), .mem_busy_i(mem_busy),
        .pc_enable_o(pc1), .ifid_enable_o(ifen1), .ifid_flush_o(iffl1),
        .idex_enable_o(iden1), .idex_flush_o(idfl1), .pipe_enable_o(pipe1),
        .stall_o(st1), .stall_cycles_o(sc1), .flush_events_o(fe1), .freeze_cycles_o(fc1));

    hazard_flush_controller #(.LOAD_USE_BUBBLES(3), .CNT_WIDTH(32)) u3 (
        .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(uses_rt), .ex_mem_read_i(mem_read), .ex_write_register_i(ex_wr),
        .redirect_i(redirect), .mem_busy_i(mem_busy),
        .pc_enable_o(pc3), .ifid_enable_o(ifen3), .ifid_flush_o(iffl3),
        .idex_enable_o(iden3), .idex_flush_o(idfl3), .pipe_enable_o(pipe3),
        .stall_o(st3), .stall_cycles_o(sc3), .flush_events_o(fe3), .freeze_cycles_o(fc3));

    int     n_pass = 0;
    int     n_total = 0;
    int     hold_left [2];
    longint m_stall [2];
    longint m_flush [2];
    longint m_freeze [2];
    int     stall_seen [2];
    int     s1, s3;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: a hazard owes the PC a fixed number of held cycles; freeze pauses
    // the debt, a redirect cancels it.
    task automatic model_cycle(input int k);
        logic [6:0]  act, exp;
        logic [31:0] a_sc, a_fe, a_fc;
        int          nbub;
        bit          lu;
        nbub = (k == 0) ? 1 : 3;
        act  = (k == 0) ? {pc1, ifen1, iffl1, iden1, idfl1, pipe1, st1}
                        : {pc3, ifen3, iffl3, iden3, idfl3, pipe3, st3};
        a_sc = (k == 0) ? sc1 : sc3;
        a_fe = (k == 0) ? fe1 : fe3;
        a_fc = (k == 0) ? fc1 : fc3;
        lu = mem_read && (ex_wr != 0) &&
             ((ex_wr == id_rs) || (uses_rt && (ex_wr == id_rt)));
        if (reset) begin
            hold_left[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0; m_freeze[k] = 0;
        end
        chk((k == 0) ? "cnt_stall_b1"  : "cnt_stall_b3",  a_sc, PERF ? m_stall[k]  : 0);
        chk((k == 0) ? "cnt_flush_b1"  : "cnt_flush_b3",  a_fe, PERF ? m_flush[k]  : 0);
        chk((k == 0) ? "cnt_freeze_b1" : "cnt_freeze_b3", a_fc, PERF ? m_freeze[k] : 0);
        if (reset) begin
            exp = O_DEF;
        end else if (mem_busy) begin
            exp = O_FRZ;
            m_freeze[k]++;
        end else if (redirect) begin
            exp = O_RDR;
            hold_left[k] = 0;
            m_flush[k]++;
        end else if (hold_left[k] > 0) begin
            exp = O_STL;
            hold_left[k]--;
            m_stall[k]++;
        end else if (lu) begin
            exp = O_STL;
            hold_left[k] = nbub - 1;
            m_stall[k]++;
        end else begin
            exp = O_DEF;
        end
        chk((k == 0) ? "outs_b1" : "outs_b3", longint'(act), longint'(exp));
        if (act[0]) stall_seen[k]++;
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_cycle(k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_wr = 0; uses_rt = 0;
        mem_read = 0; redirect = 0; mem_busy = 0;
    endtask

    task automatic snap();
        s1 = stall_seen[0];
        s3 = stall_seen[1];
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            hold_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_freeze[k] = 0;
            stall_seen[k] = 0;
        end
        reset = 1'b1;
        clear_in();
        idle(2);

        // Hazard inputs while reset is held must not disturb the defaults.
        mem_read = 1; ex_wr = 8; id_rs = 8;
        #1;
        chk("reset_stall_b3", st3, 0);
        chk("reset_pc_b3", pc3, 1);
        tick();
        clear_in();
        reset = 1'b0;
        idle(2);

        // Load-use on Rs.
        snap();
        mem_read = 1; ex_wr = 8; id_rs = 8;
        #1;
        chk("lu_rs_pc_b1", pc1, 0);
        chk("lu_rs_ifen_b1", ifen1, 0);
        chk("lu_rs_idfl_b1", idfl1, 1);
        tick();
        clear_in();
        #1;
        chk("lu_rs_release_b1", pc1, 1);
        idle(5);
        chk("lu_rs_len_b1", stall_seen[0] - s1, 1);
        chk("lu_rs_len_b3", stall_seen[1] - s3, 3);

        // Load-use on Rt with and without id_uses_rt, and against $0.
        snap();
        mem_read = 1; ex_wr = 9; id_rt = 9; id_rs = 3; uses_rt = 1;
        tick(); clear_in(); idle(5);
        chk("lu_rt_len_b1", stall_seen[0] - s1, 1);
        chk("lu_rt_len_b3", stall_seen[1] - s3, 3);
        snap();
        mem_read = 1; ex_wr = 9; id_rt = 9; id_rs = 3; uses_rt = 0;
        tick(); clear_in(); idle(3);
        chk("lu_rt_unused_b3", stall_seen[1] - s3, 0);
        snap();
        mem_read = 1; ex_wr = 0; id_rt = 0; id_rs = 0; uses_rt = 1;
        tick(); clear_in(); idle(3);
        chk("lu_zero_reg_b3", stall_seen[1] - s3, 0);

        // Redirect during the stall aborts the remaining bubbles.
        snap();
        mem_read = 1; ex_wr = 8; id_rs = 8;
        tick(); clear_in();
        tick();
        redirect = 1;
        #1;
        chk("rdr_iffl_b3", iffl3, 1);
        chk("rdr_idfl_b3", idfl3, 1);
        chk("rdr_pc_b3", pc3, 1);
        chk("rdr_stall_b3", st3, 0);
        tick();
        redirect = 0;
        #1;
        chk("rdr_after_b3", st3, 0);
        idle(4);
        chk("rdr_len_b3", stall_seen[1] - s3, 2);

        // Four-cycle freeze in the middle of a three-bubble stall.
        snap();
        mem_read = 1; ex_wr = 8; id_rs = 8;
        tick(); clear_in();
        tick();
        mem_busy = 1;
        #1;
        chk("frz_pc_b3", pc3, 0);
        chk("frz_pipe_b3", pipe3, 0);
        idle(4);
        mem_busy = 0;
        #1;
        chk("frz_resume_b3", st3, 1);
        idle(5);
        chk("frz_len_b3", stall_seen[1] - s3, 7);
        chk("frz_len_b1", stall_seen[0] - s1, 5);

        // Busy outranks redirect and load-use; the flush follows once busy drops.
        mem_read = 1; ex_wr = 8; id_rs = 8; redirect = 1; mem_busy = 1;
        #1;
        chk("prio_iffl_b3", iffl3, 0);
        chk("prio_idfl_b3", idfl3, 0);
        chk("prio_stall_b3", st3, 1);
        idle(2);
        mem_busy = 0;
        #1;
        chk("prio_flush_b3", iffl3, 1);
        chk("prio_pc_b3", pc3, 1);
        tick();
        clear_in();
        idle(3);

        // Asynchronous reset in the middle of a stall.
        mem_read = 1; ex_wr = 8; id_rs = 8;
        tick(); clear_in();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc_b3", pc3, 1);
        chk("arst_stall_b3", st3, 0);
        chk("arst_idfl_b3", idfl3, 0);
        chk("arst_cnt_b3", sc3, 0);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            redirect = 1; tick();
            redirect = 0; tick();
        end
        tick();
        chk("flush_count_b3", fe3, PERF ? 2 : 0);
        chk("freeze_count_b3", fc3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
